// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
//   LATENCY     : cycles from input transfer to out_valid
//   prod_width  : product width for a given operand width
//   bw_corr     : Baugh-Wooley correction constant (ones at bit w and bit 2w-1)
//   csa_rows    : number of rows present at a given reduction level
//   csa_levels  : number of 3:2 levels needed to reach two rows
package wallace_pkg;

  localparam int unsigned LATENCY = 3;

  function automatic int unsigned prod_width(int unsigned w);
    return 2 * w;
  endfunction

  function automatic logic [63:0] bw_corr(int unsigned w);
    logic [63:0] c;
    c = '0;
    c[w] = 1'b1;
    c[2*w-1] = 1'b1;
    return c;
  endfunction

  // Each level turns every complete group of three rows into two; leftovers pass down.
  function automatic int unsigned csa_rows(int unsigned w, int unsigned lvl);
    int unsigned n;
    n = w;
    for (int unsigned i = 0; i < lvl; i++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int unsigned csa_levels(int unsigned w);
    int unsigned n;
    int unsigned l;
    n = w;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell.
//   a_i, b_i, c_i : addends and carry in
//   s_o, c_o      : sum and carry out
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/half_add.sv
// One-bit half adder cell.
//   a_i, b_i : addends
//   s_o, c_o : sum and carry out
module half_add (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace carry-save reduction of WIDTH partial-product rows.
//   rows_i  : WIDTH rows, each 2*WIDTH bits, already shifted into place
//   sum_o   : sum vector
//   carry_o : carry vector (already shifted); sum_o + carry_o == sum of rows mod 2^(2*WIDTH)
module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0][2*WIDTH-1:0] rows_i,
  output logic [2*WIDTH-1:0]            sum_o,
  output logic [2*WIDTH-1:0]            carry_o
);
  localparam int unsigned PW     = prod_width(WIDTH);
  localparam int unsigned NumLvl = csa_levels(WIDTH);

  wire [PW-1:0] lvl [NumLvl+1][WIDTH];

  for (genvar r = 0; r < WIDTH; r++) begin : g_in
    assign lvl[0][r] = rows_i[r];
  end

  for (genvar l = 0; l < NumLvl; l++) begin : g_lvl
    localparam int unsigned N = csa_rows(WIDTH, l);
    localparam int unsigned G = N / 3;
    localparam int unsigned R = N % 3;

    for (genvar k = 0; k < G; k++) begin : g_grp
      wire [PW-1:0] s;
      wire [PW-2:0] c;
      for (genvar b = 0; b < PW - 1; b++) begin : g_bit
        full_add u_fa (
          .a_i(lvl[l][3*k][b]),
          .b_i(lvl[l][3*k+1][b]),
          .c_i(lvl[l][3*k+2][b]),
          .s_o(s[b]),
          .c_o(c[b])
        );
      end
      // Carry out of the top column falls outside the product and is dropped.
      assign s[PW-1] = lvl[l][3*k][PW-1] ^ lvl[l][3*k+1][PW-1] ^ lvl[l][3*k+2][PW-1];
      assign lvl[l+1][2*k]   = s;
      assign lvl[l+1][2*k+1] = {c, 1'b0};
    end

    if (R == 2) begin : g_pair
      wire [PW-1:0] s;
      wire [PW-2:0] c;
      for (genvar b = 0; b < PW - 1; b++) begin : g_bit
        half_add u_ha (
          .a_i(lvl[l][3*G][b]),
          .b_i(lvl[l][3*G+1][b]),
          .s_o(s[b]),
          .c_o(c[b])
        );
      end
      assign s[PW-1] = lvl[l][3*G][PW-1] ^ lvl[l][3*G+1][PW-1];
      assign lvl[l+1][2*G]   = s;
      assign lvl[l+1][2*G+1] = {c, 1'b0};
    end else if (R == 1) begin : g_pass
      assign lvl[l+1][2*G] = lvl[l][3*G];
    end

    for (genvar r = 2 * G + R; r < WIDTH; r++) begin : g_zero
      assign lvl[l+1][r] = '0;
    end
  end

  assign sum_o   = lvl[NumLvl][0];
  assign carry_o = lvl[NumLvl][1];
endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH multiplier, signed (Baugh-Wooley) or unsigned per transaction.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake; in_a, in_b, in_signed travel together
//   out_valid/out_ready   : product handshake; out_p (2*WIDTH) and out_signed tag
// Pipeline: input capture -> S1 partial-product rows -> S2 carry-save pair -> S3 product.
// A single global stall freezes every stage while the output is blocked.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_signed
);
  localparam int unsigned PW     = prod_width(WIDTH);
  localparam int          W      = int'(WIDTH);
  localparam logic [63:0] BwCorr = bw_corr(WIDTH);

  logic stall, adv;

  logic                         v1_q, sgn1_q;
  logic [WIDTH-1:0]             a1_q, b1_q;
  logic                         v2_q, sgn2_q;
  logic [WIDTH-1:0][PW-1:0]     rows2_q, rows_d;
  logic                         v3_q, sgn3_q;
  logic [PW-1:0]                sum3_q, carry3_q, csa_sum, csa_carry;
  logic                         out_valid_q, out_signed_q;
  logic [PW-1:0]                out_p_q, out_p_d;

  assign stall    = out_valid_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // Signed mode inverts the cross terms that involve exactly one operand MSB, and the
  // two correction ones sit in bit positions that row 0 and the last row leave empty.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      rows_d[i] = '0;
      for (int j = 0; j < W; j++) begin
        rows_d[i][i+j] = (a1_q[j] & b1_q[i]) ^ (sgn1_q & ((i == W - 1) != (j == W - 1)));
      end
    end
    rows_d[0][WIDTH]      = sgn1_q & BwCorr[WIDTH];
    rows_d[W-1][PW-1]     = sgn1_q & BwCorr[PW-1];
  end

  wallace_csa_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .rows_i (rows2_q),
    .sum_o  (csa_sum),
    .carry_o(csa_carry)
  );

  assign out_p_d = sum3_q + carry3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_p_q      <= '0;
      out_signed_q <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      if (in_valid) begin
        a1_q   <= in_a;
        b1_q   <= in_b;
        sgn1_q <= in_signed;
      end
      if (v1_q) begin
        rows2_q <= rows_d;
        sgn2_q  <= sgn1_q;
      end
      if (v2_q) begin
        sum3_q   <= csa_sum;
        carry3_q <= csa_carry;
        sgn3_q   <= sgn2_q;
      end
      if (v3_q) begin
        out_p_q      <= out_p_d;
        out_signed_q <= sgn3_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_p      = out_p_q;
  assign out_signed = out_signed_q;
endmodule
